snn_mac_scheduler: RTL and testbench
====================================

Name: snn_mac_scheduler

Overview:
- Sequences one shared 5-input MAC (8-bit weights, 8-bit sum) across all neurons of a spiking layer for one timestep.
- Per neuron: fetches N_GROUPS pixel-groups and weight words, accumulates the MAC sums, then updates a membrane potential with threshold, reset and leak.
- Emits spike events through a valid/ready handshake.
- Sits between pixel/weight memories and the next layer's spike input FIFO.

Parameters:
- N_NEURONS, 10, neurons served per timestep
- N_GROUPS, 4, 5-pixel groups per neuron (fan-in = 5*N_GROUPS)
- W, 8, weight and mac_sum width
- VMEM_W, 12, membrane potential width, signed
- THRESH, 64, firing threshold, signed, VMEM_W bits
- LEAK, 2, per-timestep leak magnitude for non-firing neurons

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a timestep; ignored unless IDLE
- clear  in  1  in IDLE, zeroes all membrane potentials in one cycle
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after last neuron completes
- pix_addr  out  clog2(N_GROUPS)  pixel-group address
- pix_data  in  5  spike bits of the addressed group, valid 1 cycle after address
- w_rd_en  out  1  weight memory read strobe
- w_addr  out  clog2(N_NEURONS*N_GROUPS)  equals n*N_GROUPS+g
- w_data  in  5*W  five packed weights, valid 1 cycle after w_rd_en
- mac_pixels  out  5  to MAC; registered copy of pix_data
- mac_weights  out  5*W  to MAC; registered copy of w_data
- mac_sum  in  W  MAC result, combinational from mac_pixels/mac_weights, signed
- spike_valid  out  1  spike event available
- spike_id  out  clog2(N_NEURONS)  index of firing neuron
- spike_ready  in  1  consumer accepts spike

Behaviour:
- Reset: state IDLE; all outputs 0; neuron/group counters 0; accumulator 0; all vmem 0.
- States: IDLE, FETCH, LATCH, ACC, UPDATE, EMIT, DONE.
- IDLE:
  - clear=1 zeroes vmem.
  - start=1 zeroes n, g and acc, then goes to FETCH.
  - If start and clear are high together, clear takes effect and the transition to FETCH also occurs.
- FETCH: assert w_rd_en and drive pix_addr=g, w_addr=n*N_GROUPS+g; go to LATCH.
- LATCH: register pix_data/w_data onto mac_pixels/mac_weights; go to ACC.
- ACC:
  - acc += sign-extended mac_sum; acc is VMEM_W+2 bits, so no overflow is possible.
  - If g<N_GROUPS-1: g++, go to FETCH; else go to UPDATE.
- UPDATE:
  - v = sat(vmem[n] + acc) to VMEM_W signed range [-2^(VMEM_W-1), 2^(VMEM_W-1)-1].
  - If v>=THRESH: vmem[n]=0, go to EMIT.
  - Otherwise vmem[n] = (v>LEAK) ? v-LEAK : (v>=0 ? 0 : v), then advance.
- EMIT:
  - spike_valid=1, spike_id=n.
  - spike_id is held stable until spike_ready=1; the transfer occurs that cycle.
  - spike_valid drops the next cycle unless a new EMIT follows; then advance.
- Advance:
  - If n<N_NEURONS-1: n++, g=0, acc=0, go to FETCH.
  - Otherwise go to DONE.
- DONE: done=1 for one cycle, go to IDLE.
- Latency per neuron: 3*N_GROUPS+1 cycles, plus ≥1 in EMIT when firing.
  - A default timestep with no spikes is 10*13+1 = 131 cycles from the start pulse to done.
- Neurons are processed strictly in ascending order, so spike_ids are emitted ascending within a timestep.
- start or clear while busy: no effect.
- rst at any point, including mid-EMIT: immediate return to reset state; the in-flight spike is lost and vmem is zeroed.

Decomposition:
- Shared package snn_pkg holds:
  - the state enum;
  - localparams for address widths (clog2 of N_GROUPS, N_NEURONS*N_GROUPS);
  - the signed saturation function, reused by later layers.
- One sub-module, snn_vmem_bank: N_NEURONS x VMEM_W register file with one read port (async), one write port, and a synchronous bulk clear; reset on rst.
- The MAC itself stays external; this block only drives it.

Test Plan:
- Reset with bench holding arbitrary inputs -> all outputs 0, busy=0; start held low keeps IDLE indefinitely.
- mac_sum forced to 20, spike_ready=1, start -> acc=80 per neuron, spikes emitted with ids 0..9 in order, vmem all 0 afterwards, one done pulse.
- mac_sum=10, start -> no spikes, done at cycle 131, every vmem=38; second start -> vmem 78>=64, all ten neurons fire.
- mac_sum=20, spike_ready low 5 cycles at neuron 3 -> spike_valid held high, spike_id=3 stable, no FETCH for neuron 4 until the handshake.
- mac_sum=-128, four consecutive starts -> vmem -512, -1024, -1536, -2048; fifth start -> stays at -2048 (saturation, no leak on negatives).
- start pulsed mid-timestep -> ignored. Separately, rst asserted during EMIT -> spike_valid falls asynchronously, state IDLE, vmem 0; following start behaves as from reset.

Source files
------------

// File: rtl/snn_mac_scheduler_pkg.sv
// rtl/snn_mac_scheduler_pkg.sv - shared constants, state encoding and saturation helper for the SNN layer
// Ports: none (package snn_pkg, imported by the scheduler, its vmem bank and interface)
package snn_pkg;

  localparam int N_NEURONS = 10;
  localparam int N_GROUPS  = 4;
  localparam int W         = 8;
  localparam int VMEM_W    = 12;

  localparam logic signed [VMEM_W-1:0] THRESH = VMEM_W'(64);
  localparam logic signed [VMEM_W-1:0] LEAK   = VMEM_W'(2);

  localparam int G_W   = $clog2(N_GROUPS);
  localparam int N_W   = $clog2(N_NEURONS);
  localparam int WA_W  = $clog2(N_NEURONS * N_GROUPS);
  localparam int ACC_W = VMEM_W + 2;
  // vmem + acc needs one bit beyond the accumulator
  localparam int SUM_W = ACC_W + 1;

  localparam int VMAX = 2 ** (VMEM_W - 1) - 1;
  localparam int VMIN = -(2 ** (VMEM_W - 1));

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_FETCH  = 3'd1;
  localparam state_t S_LATCH  = 3'd2;
  localparam state_t S_ACC    = 3'd3;
  localparam state_t S_UPDATE = 3'd4;
  localparam state_t S_EMIT   = 3'd5;
  localparam state_t S_DONE   = 3'd6;

  // Clamp a wide signed sum into the signed VMEM_W range.
  function automatic logic signed [VMEM_W-1:0] sat_vmem(input logic signed [SUM_W-1:0] x);
    if (x > $signed(SUM_W'(VMAX)))
      return VMEM_W'(VMAX);
    else if (x < $signed(SUM_W'(VMIN)))
      return VMEM_W'(VMIN);
    else
      return x[VMEM_W-1:0];
  endfunction

endpackage

// File: rtl/snn_mac_scheduler_if.sv
// rtl/snn_mac_scheduler_if.sv - memory, MAC and spike-stream bundle of the scheduler
// master: pix_addr/w_rd_en/w_addr out, pix_data/w_data in, mac_pixels/mac_weights out,
//         mac_sum in, spike_valid/spike_id out, spike_ready in. slave: mirror image.
interface snn_mac_scheduler_if;
  import snn_pkg::*;

  logic [G_W-1:0]   pix_addr;
  logic [4:0]       pix_data;
  logic             w_rd_en;
  logic [WA_W-1:0]  w_addr;
  logic [5*W-1:0]   w_data;
  logic [4:0]       mac_pixels;
  logic [5*W-1:0]   mac_weights;
  logic [W-1:0]     mac_sum;
  logic             spike_valid;
  logic [N_W-1:0]   spike_id;
  logic             spike_ready;

  modport master (
    output pix_addr, w_rd_en, w_addr, mac_pixels, mac_weights, spike_valid, spike_id,
    input  pix_data, w_data, mac_sum, spike_ready
  );

  modport slave (
    input  pix_addr, w_rd_en, w_addr, mac_pixels, mac_weights, spike_valid, spike_id,
    output pix_data, w_data, mac_sum, spike_ready
  );

endinterface

// File: rtl/snn_vmem_bank.sv
// rtl/snn_vmem_bank.sv - N_NEURONS x VMEM_W membrane potential register file
// Ports: clk, rst (async, high), clr (bulk zero), wr_en/wr_addr/wr_data (write port),
//        rd_addr/rd_data (asynchronous read port)
module snn_vmem_bank
  import snn_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [N_W-1:0]           wr_addr,
  input  logic signed [VMEM_W-1:0] wr_data,
  input  logic [N_W-1:0]           rd_addr,
  output logic signed [VMEM_W-1:0] rd_data
);

  logic signed [VMEM_W-1:0] mem [N_NEURONS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_NEURONS; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < N_NEURONS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/snn_mac_scheduler.sv
// rtl/snn_mac_scheduler.sv - time-multiplexes one 5-input MAC over all neurons of a spiking layer
// Ports: clk, rst (async, high), start (timestep pulse), clear (zero vmem in IDLE),
//        busy, done (one-cycle pulse), bus (memory fetch, MAC drive, spike stream)
module snn_mac_scheduler
  import snn_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                clear,
  output logic                busy,
  output logic                done,
  snn_mac_scheduler_if.master bus
);

  state_t                   state;
  logic [N_W-1:0]           n;
  logic [G_W-1:0]           g;
  logic signed [ACC_W-1:0]  acc;

  logic signed [ACC_W-1:0]  mac_ext;
  logic signed [VMEM_W-1:0] vmem_rd;
  logic signed [SUM_W-1:0]  vm_sum;
  logic signed [VMEM_W-1:0] v;
  logic signed [VMEM_W-1:0] leaked;
  logic signed [VMEM_W-1:0] wr_data;
  logic                     fire;
  logic                     last_g;
  logic                     last_n;
  logic                     advance;

  assign mac_ext = {{(ACC_W - W){bus.mac_sum[W-1]}}, bus.mac_sum};
  assign vm_sum  = $signed({{(SUM_W - VMEM_W){vmem_rd[VMEM_W-1]}}, vmem_rd})
                 + $signed({acc[ACC_W-1], acc});
  assign v       = sat_vmem(vm_sum);
  assign fire    = (v >= THRESH);

  // Leak pulls positive potentials toward zero without crossing it; negatives are left alone.
  always_comb begin
    leaked = v;
    if (v > LEAK)
      leaked = v - LEAK;
    else if (!v[VMEM_W-1])
      leaked = '0;
  end

  assign wr_data = fire ? '0 : leaked;
  assign last_g  = (g == G_W'(N_GROUPS - 1));
  assign last_n  = (n == N_W'(N_NEURONS - 1));
  // A neuron finishes either in UPDATE without firing or when its spike is accepted.
  assign advance = ((state == S_UPDATE) && !fire) || ((state == S_EMIT) && bus.spike_ready);

  snn_vmem_bank u_vmem (
    .clk     (clk),
    .rst     (rst),
    .clr     ((state == S_IDLE) && clear),
    .wr_en   (state == S_UPDATE),
    .wr_addr (n),
    .wr_data (wr_data),
    .rd_addr (n),
    .rd_data (vmem_rd)
  );

  // Handshake outputs decode straight from state so rst removes a pending spike at once.
  assign busy            = (state != S_IDLE);
  assign done            = (state == S_DONE);
  assign bus.w_rd_en     = (state == S_FETCH);
  assign bus.pix_addr    = (state == S_FETCH) ? g : '0;
  assign bus.w_addr      = (state == S_FETCH) ? (WA_W'(n) * WA_W'(N_GROUPS) + WA_W'(g)) : '0;
  assign bus.spike_valid = (state == S_EMIT);
  assign bus.spike_id    = (state == S_EMIT) ? n : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      n               <= '0;
      g               <= '0;
      acc             <= '0;
      bus.mac_pixels  <= '0;
      bus.mac_weights <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            n     <= '0;
            g     <= '0;
            acc   <= '0;
            state <= S_FETCH;
          end
        end
        S_FETCH: state <= S_LATCH;
        S_LATCH: begin
          bus.mac_pixels  <= bus.pix_data;
          bus.mac_weights <= bus.w_data;
          state           <= S_ACC;
        end
        S_ACC: begin
          acc <= acc + mac_ext;
          if (last_g) begin
            state <= S_UPDATE;
          end else begin
            g     <= g + G_W'(1);
            state <= S_FETCH;
          end
        end
        S_UPDATE: if (fire) state <= S_EMIT;
        S_EMIT:   ;
        S_DONE:   state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase

      if (advance) begin
        if (last_n) begin
          state <= S_DONE;
        end else begin
          n     <= n + N_W'(1);
          g     <= '0;
          acc   <= '0;
          state <= S_FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_snn_mac_scheduler.sv
// tb/tb_snn_mac_scheduler.sv - directed self-checking bench for snn_mac_scheduler
module tb_snn_mac_scheduler;
  import snn_pkg::*;

  localparam logic [5*W-1:0] W_PAT = 40'hA1B2C3D4E5;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic clear;
  logic busy;
  logic done;

  snn_mac_scheduler_if bus ();

  snn_mac_scheduler dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .clear (clear),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int spikes[$];
  int cycles;
  int fidx;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_vmem(input string tag, input int exp);
    for (int i = 0; i < N_NEURONS; i++) check(tag, dut.u_vmem.mem[i], exp);
  endtask

  task automatic check_spikes(input string tag, input int exp_n);
    check({tag, "_count"}, spikes.size(), exp_n);
    for (int i = 0; i < spikes.size(); i++) check({tag, "_id"}, spikes[i], i);
  endtask

  // One timestep. Fetch addresses are checked against a running index: w_addr walks 0..39.
  task automatic run_ts(input int stall_id, input bit poke);
    int stall_cnt;
    stall_cnt = 0;
    fidx = 0;
    spikes.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    while (!done && cycles < 400) begin
      start = (poke && cycles == 40);
      if (bus.w_rd_en) begin
        check("fetch_w_addr", bus.w_addr, fidx);
        check("fetch_pix_addr", bus.pix_addr, fidx % N_GROUPS);
        fidx++;
      end
      if (stall_cnt == 0 && bus.spike_valid && int'(bus.spike_id) == stall_id) stall_cnt = 1;
      if (stall_cnt >= 1 && stall_cnt <= 5) begin
        check("stall_valid", bus.spike_valid, 1);
        check("stall_id", bus.spike_id, stall_id);
        check("stall_no_fetch", bus.w_rd_en, 0);
        bus.spike_ready = 1'b0;
        stall_cnt++;
      end else begin
        bus.spike_ready = 1'b1;
      end
      if (bus.spike_valid && bus.spike_ready) spikes.push_back(int'(bus.spike_id));
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    bus.spike_ready = 1'b1;
    check("done_seen", done, 1);
    check("fetch_count", fidx, N_NEURONS * N_GROUPS);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    int wait_cnt;
    // Reset while holding arbitrary inputs.
    rst = 1'b1;
    start = 1'b1;
    clear = 1'b1;
    bus.pix_data = 5'h1B;
    bus.w_data = 40'hFFEEDDCCBB;
    bus.mac_sum = 8'h7F;
    bus.spike_ready = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_w_rd_en", bus.w_rd_en, 0);
    check("rst_w_addr", bus.w_addr, 0);
    check("rst_pix_addr", bus.pix_addr, 0);
    check("rst_spike_valid", bus.spike_valid, 0);
    check("rst_spike_id", bus.spike_id, 0);
    check("rst_mac_pixels", bus.mac_pixels, 0);
    check("rst_mac_weights", bus.mac_weights === '0, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    bus.spike_ready = 1'b1;
    bus.pix_data = 5'h15;
    bus.w_data = W_PAT;
    repeat (20) @(negedge clk);
    check("idle_hold_busy", busy, 0);
    check("idle_hold_fetch", bus.w_rd_en, 0);

    // acc = 80 per neuron: every neuron fires, 10*14+1 cycles.
    bus.mac_sum = 8'd20;
    run_ts(-1, 1'b0);
    check("fire_all_cycles", cycles, 141);
    check_spikes("fire_all", 10);
    check_vmem("fire_all_vmem", 0);
    check("mac_pixels_copy", bus.mac_pixels, 5'h15);
    check("mac_weights_copy", bus.mac_weights === W_PAT, 1);

    // acc = 40: 40-2 leak, no spikes; a start mid-run is ignored.
    bus.mac_sum = 8'd10;
    run_ts(-1, 1'b1);
    check("quiet_cycles", cycles, 131);
    check_spikes("quiet", 0);
    check_vmem("quiet_vmem", 38);

    // 38+40 = 78 >= 64: all fire again.
    run_ts(-1, 1'b0);
    check("second_cycles", cycles, 141);
    check_spikes("second", 10);
    check_vmem("second_vmem", 0);

    // Back-pressure on neuron 3 for five cycles.
    bus.mac_sum = 8'd20;
    run_ts(3, 1'b0);
    check("stall_cycles", cycles, 146);
    check_spikes("stall", 10);

    // Negative drive: -512 per step, saturating at -2048, no leak on negatives.
    bus.mac_sum = 8'h80;
    for (int k = 1; k <= 5; k++) begin
      run_ts(-1, 1'b0);
      check("neg_cycles", cycles, 131);
      check_spikes("neg", 0);
      check_vmem("neg_vmem", (k < 4) ? -512 * k : -2048);
    end

    // Clear in IDLE zeroes the bank.
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check_vmem("clear_vmem", 0);

    // rst during EMIT.
    bus.mac_sum = 8'd10;
    run_ts(-1, 1'b0);
    check_vmem("pre_rst_vmem", 38);
    bus.mac_sum = 8'd20;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cnt = 0;
    while (!bus.spike_valid && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("emit_reached", bus.spike_valid, 1);
    check("emit_first_id", bus.spike_id, 0);
    check("vmem_mid_run", dut.u_vmem.mem[5], 38);
    rst = 1'b1;
    #1;
    check("async_rst_valid", bus.spike_valid, 0);
    check("async_rst_busy", busy, 0);
    check_vmem("rst_vmem", 0);
    @(negedge clk);
    rst = 1'b0;
    bus.mac_sum = 8'd10;
    run_ts(-1, 1'b0);
    check("post_rst_cycles", cycles, 131);
    check_spikes("post_rst", 0);
    check_vmem("post_rst_vmem", 38);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
